regfile_sb: RTL and testbench

- Parametrised successor to the team's 8x8, 2-read/1-write register file.
- Adds configurable data width and depth.
- Adds optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a per-register busy scoreboard (set on issue, cleared on writeback) so the datapath controller can detect read-after-write hazards.
- Sits between the decode/issue stage (RX, RY, SEN, RS) and the writeback stage (WEN, RW, busW).

---
 rtl/regfile_sb_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared defaults and constants for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int ZERO_ADDR  = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: set on issue, cleared on writeback, with a registered busy count.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [ADDR_W-1:0] rw,
  input  logic              sen,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rx,
  input  logic [ADDR_W-1:0] ry,
  output logic              busy_x_raw,
  output logic              busy_y_raw,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             set_ok;

  // Clear is applied before set so a same-address issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    set_ok = sen & ~(ZERO_REG & (rs == ADDR_W'(ZERO_ADDR)));
    if (wen) begin
      busy_d[rw] = 1'b0;
    end
    if (set_ok) begin
      busy_d[rs] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_x_raw = busy_q[rx];
  assign busy_y_raw = busy_q[ry];
  assign busy_cnt   = cnt_q;

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Parametrised 2-read/1-write register file with optional zero register, write bypass and busy scoreboard.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] busW,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  output logic [DATA_W-1:0] busX,
  output logic [DATA_W-1:0] busY,
  input  logic              SEN,
  input  logic [ADDR_W-1:0] RS,
  output logic              busyX,
  output logic              busyY,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              busy_x_raw, busy_y_raw;
  logic              x_is_zero, y_is_zero, x_fwd, y_fwd;

  always_comb begin
    mem_d = mem_q;
    if (WEN && !(ZERO_REG && (RW == ADDR_W'(ZERO_ADDR)))) begin
      mem_d[RW] = busW;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (Clk),
    .rst        (Rst),
    .wen        (WEN),
    .rw         (RW),
    .sen        (SEN),
    .rs         (RS),
    .rx         (RX),
    .ry         (RY),
    .busy_x_raw (busy_x_raw),
    .busy_y_raw (busy_y_raw),
    .busy_cnt   (busy_cnt)
  );

  assign x_is_zero = ZERO_REG & (RX == ADDR_W'(ZERO_ADDR));
  assign y_is_zero = ZERO_REG & (RY == ADDR_W'(ZERO_ADDR));
  assign x_fwd     = BYPASS & WEN & (RW == RX);
  assign y_fwd     = BYPASS & WEN & (RW == RY);

  // A forwarded value is already available, so its pending-producer flag is hidden.
  always_comb begin
    busX  = mem_q[RX];
    busY  = mem_q[RY];
    busyX = busy_x_raw & ~x_fwd;
    busyY = busy_y_raw & ~y_fwd;
    if (x_fwd) begin
      busX = busW;
    end
    if (y_fwd) begin
      busY = busW;
    end
    if (x_is_zero) begin
      busX  = '0;
      busyX = 1'b0;
    end
    if (y_is_zero) begin
      busY  = '0;
      busyY = 1'b0;
    end
  end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed-vector bench for regfile_sb; a second instance without bypass shares all inputs.
module tb_regfile_sb;

  typedef struct {
    logic       rst;
    logic       wen;
    logic [2:0] rw;
    logic [7:0] busw;
    logic       sen;
    logic [2:0] rs;
    logic [2:0] rx;
    logic [2:0] ry;
    logic [7:0] expBusX;
    logic [7:0] expBusY;
    logic       expBusyX;
    logic       expBusyY;
    logic [3:0] expCnt;
    logic [7:0] expNbBusX;
    logic       expNbBusyX;
  } vec_t;

  logic       Clk = 1'b0;
  logic       Rst, WEN, SEN;
  logic [2:0] RW, RX, RY, RS;
  logic [7:0] busW, busX, busY, nbBusX, nbBusY;
  logic       busyX, busyY, nbBusyX, nbBusyY;
  logic [3:0] busy_cnt, nbBusyCnt;

  int vectors    = 0;
  int miscompares = 0;
  vec_t vecs [18];

  always #5 Clk = ~Clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
    .busX(busX), .busY(busY), .SEN(SEN), .RS(RS), .busyX(busyX), .busyY(busyY),
    .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dutNb (
    .Clk(Clk), .Rst(Rst), .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
    .busX(nbBusX), .busY(nbBusY), .SEN(SEN), .RS(RS), .busyX(nbBusyX), .busyY(nbBusyY),
    .busy_cnt(nbBusyCnt)
  );

  // Inputs change 1ns after the rising edge so the DUT sees them stable for the next edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge Clk);
    #1;
    Rst  = v.rst;
    WEN  = v.wen;
    RW   = v.rw;
    busW = v.busw;
    SEN  = v.sen;
    RS   = v.rs;
    RX   = v.rx;
    RY   = v.ry;
    vectors++;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at vector %0d: got %h, expected %h", name, vectors, act, exp);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    #2;
    checkOutput({tag, ".busX"},     busX,           v.expBusX);
    checkOutput({tag, ".busY"},     busY,           v.expBusY);
    checkOutput({tag, ".busyX"},    8'(busyX),      8'(v.expBusyX));
    checkOutput({tag, ".busyY"},    8'(busyY),      8'(v.expBusyY));
    checkOutput({tag, ".busy_cnt"}, 8'(busy_cnt),   8'(v.expCnt));
    checkOutput({tag, ".nb.busX"},  nbBusX,         v.expNbBusX);
    checkOutput({tag, ".nb.busyX"}, 8'(nbBusyX),    8'(v.expNbBusyX));
  endtask

  function automatic vec_t mk(input logic rst, input logic wen, input logic [2:0] rw,
                              input logic [7:0] busw, input logic sen, input logic [2:0] rs,
                              input logic [2:0] rx, input logic [2:0] ry,
                              input logic [7:0] ebx, input logic [7:0] eby,
                              input logic ebsx, input logic ebsy, input logic [3:0] ecnt,
                              input logic [7:0] enbx, input logic enbsx);
    vec_t v;
    v.rst = rst; v.wen = wen; v.rw = rw; v.busw = busw; v.sen = sen; v.rs = rs;
    v.rx = rx; v.ry = ry; v.expBusX = ebx; v.expBusY = eby; v.expBusyX = ebsx;
    v.expBusyY = ebsy; v.expCnt = ecnt; v.expNbBusX = enbx; v.expNbBusyX = enbsx;
    return v;
  endfunction

  initial begin
    vec_t idle;
    //            rst wen rw  busw   sen rs  rx  ry  | busX   busY   bX  bY  cnt | nbX    nbbX
    vecs[0]  = mk(0,  1,  0,  8'hAA, 0,  0,  0,  0,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[1]  = mk(0,  0,  0,  8'h00, 0,  0,  0,  5,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[2]  = mk(0,  1,  3,  8'h5C, 0,  0,  3,  1,    8'h5C, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[3]  = mk(0,  0,  0,  8'h00, 0,  0,  3,  3,    8'h5C, 8'h5C, 0,  0,  0,   8'h5C, 0);
    vecs[4]  = mk(0,  1,  4,  8'h11, 0,  0,  4,  3,    8'h11, 8'h5C, 0,  0,  0,   8'h00, 0);
    vecs[5]  = mk(0,  0,  0,  8'h00, 1,  6,  6,  0,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[6]  = mk(0,  0,  0,  8'h00, 0,  0,  6,  6,    8'h00, 8'h00, 1,  1,  1,   8'h00, 1);
    vecs[7]  = mk(0,  1,  6,  8'h77, 0,  0,  6,  4,    8'h77, 8'h11, 0,  0,  1,   8'h00, 1);
    vecs[8]  = mk(0,  0,  0,  8'h00, 1,  0,  6,  0,    8'h77, 8'h00, 0,  0,  0,   8'h77, 0);
    vecs[9]  = mk(0,  0,  0,  8'h00, 1,  2,  0,  0,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[10] = mk(0,  1,  2,  8'h9E, 1,  2,  2,  2,    8'h9E, 8'h9E, 0,  0,  1,   8'h00, 1);
    vecs[11] = mk(0,  0,  0,  8'h00, 0,  0,  2,  0,    8'h9E, 8'h00, 1,  0,  1,   8'h9E, 1);
    vecs[12] = mk(0,  1,  1,  8'h3C, 1,  1,  0,  0,    8'h00, 8'h00, 0,  0,  1,   8'h00, 0);
    vecs[13] = mk(0,  0,  0,  8'h00, 1,  7,  1,  7,    8'h3C, 8'h00, 1,  0,  2,   8'h3C, 1);
    vecs[14] = mk(0,  0,  0,  8'h00, 1,  2,  2,  7,    8'h9E, 8'h00, 1,  1,  3,   8'h9E, 1);
    vecs[15] = mk(1,  1,  1,  8'hFF, 1,  5,  1,  7,    8'hFF, 8'h00, 0,  1,  3,   8'h3C, 1);
    vecs[16] = mk(0,  0,  0,  8'h00, 0,  0,  5,  1,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);
    vecs[17] = mk(0,  0,  0,  8'h00, 0,  0,  3,  4,    8'h00, 8'h00, 0,  0,  0,   8'h00, 0);

    idle = mk(0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0);
    Rst = 1'b1; WEN = 1'b0; SEN = 1'b0; RW = '0; RS = '0; RX = '0; RY = '0; busW = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
    end

    // Issue to every non-zero register; the count should saturate at DEPTH-1 with r0 hardwired.
    for (int r = 1; r < 8; r++) begin
      vec_t v;
      v = idle; v.sen = 1'b1; v.rs = 3'(r);
      applyStimulus(v);
      #2;
      checkOutput($sformatf("fill%0d.busy_cnt", r), 8'(busy_cnt), 8'(r - 1));
    end
    begin
      vec_t v;
      v = idle; v.sen = 1'b1; v.rs = 3'd0; v.rx = 3'd7; v.ry = 3'd0;
      applyStimulus(v);
      #2;
      checkOutput("full.busy_cnt", 8'(busy_cnt), 8'd7);
      checkOutput("full.busyX", 8'(busyX), 8'd1);
      checkOutput("full.busyY", 8'(busyY), 8'd0);
    end

    // Write back every register in turn; each writeback retires exactly one busy entry.
    for (int r = 1; r < 8; r++) begin
      vec_t v;
      v = idle; v.wen = 1'b1; v.rw = 3'(r); v.busw = 8'(r * 8'h13); v.rx = 3'(r);
      applyStimulus(v);
      #2;
      checkOutput($sformatf("drain%0d.busy_cnt", r), 8'(busy_cnt), 8'(8 - r));
      checkOutput($sformatf("drain%0d.nbBusyX", r), 8'(nbBusyX), 8'd1);
    end
    for (int r = 1; r < 8; r++) begin
      vec_t v;
      v = idle; v.rx = 3'(r); v.ry = 3'(8 - r);
      applyStimulus(v);
      #2;
      checkOutput($sformatf("read%0d.busX", r), busX, 8'(r * 8'h13));
      checkOutput($sformatf("read%0d.busY", r), busY, 8'((8 - r) * 8'h13));
      checkOutput($sformatf("read%0d.busy_cnt", r), 8'(busy_cnt), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_sb
